// File: rtl/button_gesture_pkg.sv
// Shared definitions for the button gesture classifier and the blocks that
// consume its events (counters, display). State encoding is 3 bits, IDLE=0.
package button_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_GAP    = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_HELD   = 3'd4
  } state_t;

  localparam logic [1:0] EVT_NONE   = 2'b00;
  localparam logic [1:0] EVT_SHORT  = 2'b01;
  localparam logic [1:0] EVT_LONG   = 2'b10;
  localparam logic [1:0] EVT_DOUBLE = 2'b11;

  // Timer width able to hold max(long_ticks, double_ticks).
  function automatic int unsigned timer_width(input int unsigned long_ticks,
                                              input int unsigned double_ticks);
    int unsigned max_ticks;
    if (long_ticks > double_ticks) begin
      max_ticks = long_ticks;
    end else begin
      max_ticks = double_ticks;
    end
    return $clog2(max_ticks + 32'd1);
  endfunction

endpackage

// File: rtl/button_gesture_if.sv
// Gesture classifier bus: debounced edge pulses and timebase in, event out.
interface button_gesture_if;
  logic       tick_i;
  logic       up_i;
  logic       dn_i;
  logic       evt_valid_o;
  logic [1:0] evt_o;
  logic       busy_o;

  modport master (
    output tick_i, up_i, dn_i,
    input  evt_valid_o, evt_o, busy_o
  );

  modport slave (
    input  tick_i, up_i, dn_i,
    output evt_valid_o, evt_o, busy_o
  );
endinterface

// File: rtl/button_gesture_timer.sv
// Saturating tick counter used by the gesture FSM. Clear wins over enable.
module gesture_timer #(
  parameter int unsigned TW = 32'd4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [TW-1:0] count_o
);

  localparam logic [TW-1:0] COUNT_MAX = {TW{1'b1}};
  localparam logic [TW-1:0] COUNT_ONE = {{(TW-1){1'b0}}, 1'b1};

  logic [TW-1:0] count_r;

  // Count enabled ticks, stop at all-ones, restart from zero on clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {TW{1'b0}};
    end else if (clr_i) begin
      count_r <= {TW{1'b0}};
    end else if (en_i && (count_r != COUNT_MAX)) begin
      count_r <= count_r + COUNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count_o = count_r;

endmodule

// File: rtl/button_gesture.sv
// Classifies debounced press/release pulses into short, long and double
// click events. One timer measures both hold time and release gap; it is
// restarted on every state change.
module button_gesture
  import button_pkg::*;
#(
  parameter int unsigned LONG_TICKS   = 32'd50,
  parameter int unsigned DOUBLE_TICKS = 32'd20
) (
  input  logic             clk,
  input  logic             rst,
  button_gesture_if.slave  bus
);

  localparam int unsigned TW = timer_width(LONG_TICKS, DOUBLE_TICKS);
  localparam logic [TW-1:0] LONG_LAST   = TW'(LONG_TICKS - 32'd1);
  localparam logic [TW-1:0] DOUBLE_LAST = TW'(DOUBLE_TICKS - 32'd1);

  state_t        state_r;
  state_t        state_next_s;
  logic [1:0]    evt_next_s;
  logic [1:0]    evt_r;
  logic          evt_valid_r;
  logic          busy_r;
  logic [TW-1:0] timer_s;
  logic          timer_clr_s;
  logic          up_v_s;
  logic          dn_v_s;
  logic          long_to_s;
  logic          double_to_s;

  // Simultaneous press and release pulses are a glitch and count as neither.
  assign up_v_s = bus.up_i & ~bus.dn_i;
  assign dn_v_s = bus.dn_i & ~bus.up_i;

  assign long_to_s   = bus.tick_i && (timer_s == LONG_LAST);
  assign double_to_s = bus.tick_i && (timer_s == DOUBLE_LAST);

  assign timer_clr_s = (state_next_s != state_r);

  gesture_timer #(
    .TW (TW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (timer_clr_s),
    .en_i    (bus.tick_i),
    .count_o (timer_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and event decode; timeouts take priority over edges.
  always_comb begin
    state_next_s = state_r;
    evt_next_s   = EVT_NONE;
    case (state_r)
      ST_IDLE: begin
        if (up_v_s) begin
          state_next_s = ST_PRESS1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PRESS1: begin
        if (long_to_s) begin
          evt_next_s   = EVT_LONG;
          state_next_s = ST_HELD;
        end else if (dn_v_s) begin
          state_next_s = ST_GAP;
        end else begin
          state_next_s = ST_PRESS1;
        end
      end
      ST_GAP: begin
        if (double_to_s) begin
          evt_next_s   = EVT_SHORT;
          state_next_s = ST_IDLE;
        end else if (up_v_s) begin
          state_next_s = ST_PRESS2;
        end else begin
          state_next_s = ST_GAP;
        end
      end
      ST_PRESS2: begin
        if (long_to_s) begin
          evt_next_s   = EVT_DOUBLE;
          state_next_s = ST_HELD;
        end else if (dn_v_s) begin
          evt_next_s   = EVT_DOUBLE;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_PRESS2;
        end
      end
      ST_HELD: begin
        if (dn_v_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_HELD;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        evt_next_s   = EVT_NONE;
      end
    endcase
  end

  // Output registers: event strobe lasts exactly one cycle, code is 00 when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid_r <= 1'b0;
      evt_r       <= EVT_NONE;
      busy_r      <= 1'b0;
    end else begin
      evt_valid_r <= (evt_next_s != EVT_NONE);
      evt_r       <= evt_next_s;
      busy_r      <= (state_next_s != ST_IDLE);
    end
  end

  assign bus.evt_valid_o = evt_valid_r;
  assign bus.evt_o       = evt_r;
  assign bus.busy_o      = busy_r;

endmodule

// File: tb/tb_button_gesture.sv
// Directed bench for button_gesture with LONG_TICKS=8, DOUBLE_TICKS=5.
module tb_button_gesture;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   cyc_cnt;
  int   n_evt;
  int   last_evt_cyc;
  logic [1:0] last_evt;
  int   bad_idle;
  bit   div_mode;

  button_gesture_if bus ();

  button_gesture #(
    .LONG_TICKS   (32'd8),
    .DOUBLE_TICKS (32'd5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter: value after an edge is that edge's index.
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Event monitor: counts strobes and flags a nonzero code outside a strobe.
  always @(negedge clk) begin
    if (bus.evt_valid_o === 1'b1) begin
      n_evt        = n_evt + 1;
      last_evt     = bus.evt_o;
      last_evt_cyc = cyc_cnt;
    end else if (bus.evt_o !== 2'b00) begin
      bad_idle = bad_idle + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive pulses, let the edge sample them, return 1 ns later.
  task automatic step(input logic up, input logic dn);
    bus.up_i = up;
    bus.dn_i = dn;
    if (div_mode) bus.tick_i = ((cyc_cnt % 4) == 0);
    else          bus.tick_i = 1'b1;
    @(posedge clk);
    #1;
    bus.up_i = 1'b0;
    bus.dn_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  // Single click: up at P0, dn at P3, short strobe at P8.
  task automatic single_click(input string tag);
    int base;
    base = n_evt;
    step(1'b1, 1'b0);
    idle(2);
    step(1'b0, 1'b1);
    idle(4);
    check({tag, "_pre_valid"}, bus.evt_valid_o, 1'b0);
    check({tag, "_pre_busy"}, bus.busy_o, 1'b1);
    step(1'b0, 1'b0);
    check({tag, "_valid"}, bus.evt_valid_o, 1'b1);
    check({tag, "_evt"}, bus.evt_o, 2'b01);
    step(1'b0, 1'b0);
    check({tag, "_busy_after"}, bus.busy_o, 1'b0);
    check({tag, "_valid_after"}, bus.evt_valid_o, 1'b0);
    idle(3);
    check({tag, "_n_evt"}, n_evt - base, 1);
  endtask

  initial begin
    int base;
    int up_cyc;
    n_checks = 0; n_pass = 0; cyc_cnt = 0; n_evt = 0; bad_idle = 0;
    last_evt = 2'b00; last_evt_cyc = 0; div_mode = 1'b0;
    bus.tick_i = 1'b1; bus.up_i = 1'b0; bus.dn_i = 1'b0;
    rst = 1'b1;

    // Reset state, with pulses present that must be ignored.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("rst_valid", bus.evt_valid_o, 1'b0);
    check("rst_evt", bus.evt_o, 2'b00);
    check("rst_busy", bus.busy_o, 1'b0);
    rst = 1'b0;
    idle(2);
    check("post_rst_busy", bus.busy_o, 1'b0);

    single_click("click");

    // Long press: strobe at P8, HELD until dn at P12, nothing at release.
    base = n_evt;
    step(1'b1, 1'b0);
    idle(7);
    check("long_pre_valid", bus.evt_valid_o, 1'b0);
    step(1'b0, 1'b0);
    check("long_valid", bus.evt_valid_o, 1'b1);
    check("long_evt", bus.evt_o, 2'b10);
    check("long_busy_held", bus.busy_o, 1'b1);
    idle(3);
    step(1'b0, 1'b1);
    check("long_rel_valid", bus.evt_valid_o, 1'b0);
    check("long_rel_busy", bus.busy_o, 1'b0);
    idle(6);
    check("long_n_evt", n_evt - base, 1);

    // Double click: up P0, dn P2, up P4, dn P6 -> double strobe at P6.
    base = n_evt;
    step(1'b1, 1'b0);
    idle(1);
    step(1'b0, 1'b1);
    idle(1);
    step(1'b1, 1'b0);
    check("dbl_busy_p2", bus.busy_o, 1'b1);
    idle(1);
    step(1'b0, 1'b1);
    check("dbl_valid", bus.evt_valid_o, 1'b1);
    check("dbl_evt", bus.evt_o, 2'b11);
    check("dbl_busy", bus.busy_o, 1'b0);
    idle(8);
    check("dbl_n_evt", n_evt - base, 1);
    check("dbl_last", last_evt, 2'b11);

    // Boundary gap: second up on the GAP timeout edge -> short only, IDLE.
    base = n_evt;
    step(1'b1, 1'b0);
    idle(2);
    step(1'b0, 1'b1);
    idle(4);
    step(1'b1, 1'b0);
    check("gap_valid", bus.evt_valid_o, 1'b1);
    check("gap_evt", bus.evt_o, 2'b01);
    check("gap_busy", bus.busy_o, 1'b0);
    idle(10);
    check("gap_busy_late", bus.busy_o, 1'b0);
    check("gap_n_evt", n_evt - base, 1);

    // Reset mid-PRESS1 at +3 (with a dn pulse that must be ignored).
    base = n_evt;
    step(1'b1, 1'b0);
    idle(2);
    rst = 1'b1;
    step(1'b0, 1'b1);
    rst = 1'b0;
    check("mid_rst_busy", bus.busy_o, 1'b0);
    check("mid_rst_valid", bus.evt_valid_o, 1'b0);
    idle(12);
    check("mid_rst_n_evt", n_evt - base, 0);
    single_click("click2");

    // Tick divider: 1 tick in 4, hold 40 cycles -> long strobe near +32.
    div_mode = 1'b1;
    base = n_evt;
    step(1'b1, 1'b0);
    up_cyc = cyc_cnt;
    idle(39);
    step(1'b0, 1'b1);
    check("div_n_evt", n_evt - base, 1);
    check("div_evt", last_evt, 2'b10);
    check("div_latency", ((last_evt_cyc - up_cyc) >= 29) && ((last_evt_cyc - up_cyc) <= 35), 1'b1);
    check("div_rel_busy", bus.busy_o, 1'b0);

    // Coincident up+dn in IDLE: glitch, no transition, no event.
    base = n_evt;
    step(1'b1, 1'b1);
    check("glitch_busy", bus.busy_o, 1'b0);
    idle(12);
    check("glitch_busy_late", bus.busy_o, 1'b0);
    check("glitch_n_evt", n_evt - base, 0);
    div_mode = 1'b0;

    check("evt_zero_when_idle", bad_idle, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/button_gesture.md
BUTTON_GESTURE -- requirements
Module: button_gesture

Interface
REQ-001 SHALL have parameter LONG_TICKS, default 50, hold duration in ticks that classifies a press as long (range 2..65535).
REQ-002 SHALL have parameter DOUBLE_TICKS, default 20, maximum release gap in ticks that makes a second press a double click (range 2..65535).
REQ-003 SHALL have port clk  input  1  single clock for the whole block, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous to clk, active-high.
REQ-005 SHALL have port tick_i  input  1  timebase enable; timers advance only on cycles where it is 1.
REQ-006 SHALL have port up_i  input  1  one-cycle pulse from the debouncer on a debounced press (rising edge).
REQ-007 SHALL have port dn_i  input  1  one-cycle pulse from the debouncer on a debounced release (falling edge).
REQ-008 SHALL have port evt_valid_o  output  1  one-cycle strobe; evt_o is valid.
REQ-009 SHALL have port evt_o  output  2  event code: 01 short, 10 long, 11 double, 00 none.
REQ-010 SHALL have port busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL implement the FSM states IDLE, PRESS1, GAP, PRESS2 and HELD.
REQ-012 SHALL use one timer, TW = clog2(max(LONG_TICKS,DOUBLE_TICKS)+1) bits wide, cleared on every state change and incremented on tick_i, saturating at its maximum value.
REQ-013 SHALL, in IDLE, go to PRESS1 on up_i.
REQ-014 SHALL, in PRESS1, go to GAP on dn_i; when the timer equals LONG_TICKS-1 and tick_i=1, emit long and go to HELD.
REQ-015 SHALL, in GAP, go to PRESS2 on up_i; when the timer equals DOUBLE_TICKS-1 and tick_i=1, emit short and go to IDLE.
REQ-016 SHALL, in PRESS2, emit double and go to IDLE on dn_i; when the timer equals LONG_TICKS-1 and tick_i=1, emit double and go to HELD.
REQ-017 SHALL, in HELD, emit nothing, and go to IDLE on dn_i.
REQ-018 SHALL register all outputs: evt_valid_o and evt_o assert exactly one cycle after the clk edge that samples the deciding input, and remain high for one cycle.
REQ-019 SHALL drive evt_o to 00 whenever evt_valid_o=0.
REQ-020 SHALL treat up_i and dn_i asserted in the same cycle as a glitch: no transition, no event, timer unaffected.
REQ-021 SHALL ignore redundant pulses (up_i in PRESS1, PRESS2 or HELD; dn_i in IDLE or GAP) without a state change or a timer clear.
REQ-022 SHALL give the timeout priority when a timeout and a valid edge fall in the same cycle (long wins over dn_i in PRESS1; short wins over up_i in GAP, with the FSM then going to IDLE and the up_i dropped).
REQ-023 SHALL emit at most one event per gesture; throughput is one event per cycle at most.

Reset
REQ-024 SHALL, while rst=1 at a clk edge, set the state to IDLE, clear the timer to 0, and drive evt_valid_o=0, evt_o=00, busy_o=0.
REQ-025 SHALL abort any in-progress gesture on reset mid-operation with no event, and ignore up_i/dn_i in the reset cycle.
REQ-026 SHALL need no input to be quiet after reset; the first up_i after release of reset is processed normally.

Structure
REQ-027 SHALL place the FSM state encoding (3 bits, IDLE=0) and the event code constants EVT_NONE/SHORT/LONG/DOUBLE in a shared package, button_pkg, for reuse by the counter and display blocks.
REQ-028 SHALL implement the timer as one sub-module, gesture_timer (clear, enable, saturating count, TW-bit output); the FSM and output registers stay in button_gesture.

Verification (LONG_TICKS=8, DOUBLE_TICKS=5, tick_i=1 unless stated)
REQ-029 SHALL check a single click: up_i, then dn_i 3 cycles later, then idle -> evt_o=01 strobe exactly 5 cycles after dn_i, busy_o low the next cycle.
REQ-030 SHALL check a long press: up_i, held for 12 cycles, then dn_i -> evt_o=10 strobe 8 cycles after up_i, no event at release.
REQ-031 SHALL check a double click: up_i, dn_i at +2, up_i at +4, dn_i at +6 -> single evt_o=11 strobe one cycle after the second dn_i, and no 01 strobe.
REQ-032 SHALL check a boundary gap: second up_i lands on the cycle where the GAP timer hits 4 -> evt_o=01 only, FSM in IDLE, the second press not counted.
REQ-033 SHALL check reset mid-PRESS1 (rst pulsed 1 cycle at +3 after up_i) -> no event, busy_o=0; the following click yields 01 normally.
REQ-034 SHALL check the tick divider: tick_i high 1 cycle in 4, long press held 40 cycles -> evt_o=10 strobe 32 cycles after up_i (+/-3), and up_i+dn_i coincident produces no event.
